// File: rtl/mips_alu_arbiter_pkg.sv
// Shared ALU control codes and response-register state encoding for the
// two-requester ALU arbiter and the datapath control unit.
package mips_alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic ctl_legal(input logic [3:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ctl_legal = 1'b1;
            default:                                             ctl_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_arbiter_alu.sv
// MIPSALU: combinational 32-bit ALU with Zero flag; unknown codes give 0.
module MIPSALU
    import mips_alu_arbiter_pkg::*;
(
    input  logic [3:0]  alu_ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_out,
    output logic        zero
);

    always_comb begin
        alu_out = 32'd0;
        case (alu_ctl)
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_ADD: alu_out = a + b;
            ALU_SUB: alu_out = a - b;
            ALU_SLT: alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_out = ~(a | b);
            default: alu_out = 32'd0;
        endcase
    end

    assign zero = (alu_out == 32'd0);

endmodule

// File: rtl/mips_alu_arbiter.sv
// Two requesters share one ALU; the winner's result lands in a single
// response register with valid/ready handshake and no bubble on refill.
module mips_alu_arbiter
    import mips_alu_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [3:0]  req0_ctl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_grant,
    input  logic        req1_valid,
    input  logic [3:0]  req1_ctl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_grant,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    output logic        rsp_err
);

    state_t      state, state_nxt;
    logic        ptr;
    logic        armed;
    logic        sel;
    logic        both;
    logic        gnt;
    logic [3:0]  sel_ctl;
    logic [31:0] sel_a, sel_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        legal;

    // armed blocks grants from reset release until the first clock edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        both      = req0_valid && req1_valid;
        sel       = 1'b0;
        if (both)
            sel = (RR_EN != 0) ? ptr : 1'b0;
        else if (req1_valid)
            sel = 1'b1;
        gnt       = armed && (req0_valid || req1_valid) &&
                    ((state == ST_EMPTY) || rsp_ready);
        req0_grant = gnt && !sel;
        req1_grant = gnt && sel;
        state_nxt = state;
        if (gnt)
            state_nxt = ST_FULL;
        else if ((state == ST_FULL) && rsp_ready)
            state_nxt = ST_EMPTY;
    end

    assign sel_ctl = sel ? req1_ctl : req0_ctl;
    assign sel_a   = sel ? req1_a   : req0_a;
    assign sel_b   = sel ? req1_b   : req0_b;
    assign legal   = ctl_legal(sel_ctl);

    MIPSALU u_alu (
        .alu_ctl (sel_ctl),
        .a       (sel_a),
        .b       (sel_b),
        .alu_out (alu_out),
        .zero    (alu_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_id   <= 1'b0;
            rsp_out  <= 32'd0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
            ptr      <= 1'b0;
        end else if (gnt) begin
            rsp_id   <= sel;
            rsp_out  <= legal ? alu_out : 32'd0;
            rsp_zero <= legal ? alu_zero : 1'b1;
            rsp_err  <= !legal;
            // pointer moves only when there was actual contention
            if (both && (RR_EN != 0))
                ptr <= !sel;
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule
